// File: rtl/input_reg_sampler_if.sv
`default_nettype none
// ============================================================================
// input_reg_sampler_if : pin/read bus between the execution unit and the
//                        bit-addressable input register.
// Revision 1.0
// ============================================================================
interface input_reg_sampler_if #(
  parameter int INPUT_NUMBER   = 8,
  parameter int INPUT_ADDR_LEN = 3
);
  logic [INPUT_NUMBER-1:0]   inputs;
  logic                      inputRd;
  logic [INPUT_ADDR_LEN-1:0] inputRdAddr;
  logic                      inputRdEdge;
  logic                      inputReadOut;
  logic                      inputReadValid;
  logic [INPUT_NUMBER-1:0]   inputImage;
  logic                      inputChanged;

  modport master (
    output inputs, inputRd, inputRdAddr, inputRdEdge,
    input  inputReadOut, inputReadValid, inputImage, inputChanged
  );

  modport slave (
    input  inputs, inputRd, inputRdAddr, inputRdEdge,
    output inputReadOut, inputReadValid, inputImage, inputChanged
  );
endinterface
`default_nettype wire

// File: rtl/input_reg_sampler.sv
`default_nettype none
// ============================================================================
// input_reg_sampler : synchronised, debounced input image with sticky
//                     per-bit change flags and single-bit addressed reads.
// Revision 1.0
// ============================================================================
module input_reg_sampler #(
  parameter int INPUT_NUMBER    = 8,
  parameter int INPUT_ADDR_LEN  = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input_reg_sampler_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [INPUT_NUMBER-1:0] r_sync1;
  logic [INPUT_NUMBER-1:0] r_sync2;
  logic [INPUT_NUMBER-1:0] r_image;
  logic [INPUT_NUMBER-1:0] r_flag;
  logic [CNT_WIDTH-1:0]    r_cnt [INPUT_NUMBER];
  logic                    r_read_out;
  logic                    r_read_valid;

  logic [INPUT_NUMBER-1:0] w_toggle;
  logic [INPUT_NUMBER-1:0] w_clr;
  logic                    w_img_bit;
  logic                    w_flag_bit;

  // Address decode; an out-of-range address matches nothing and reads 0.
  always_comb begin
    w_img_bit  = 1'b0;
    w_flag_bit = 1'b0;
    w_clr      = '0;
    w_toggle   = '0;
    for (int j = 0; j < INPUT_NUMBER; j++) begin
      w_toggle[j] = (r_sync2[j] != r_image[j]) && (r_cnt[j] == c_cnt_last);
      if (bus.inputRdAddr == INPUT_ADDR_LEN'(j)) begin
        w_img_bit  = r_image[j];
        w_flag_bit = r_flag[j];
        w_clr[j]   = bus.inputRd && bus.inputRdEdge;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_image      <= '0;
      r_flag       <= '0;
      r_read_out   <= 1'b0;
      r_read_valid <= 1'b0;
      for (int i = 0; i < INPUT_NUMBER; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= bus.inputs;
      r_sync2 <= r_sync1;
      for (int i = 0; i < INPUT_NUMBER; i++) begin
        if (r_sync2[i] == r_image[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_cnt_last) begin
          r_image[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
        end
      end
      // A toggle on the same edge as an edge-read keeps the flag set.
      r_flag       <= w_toggle | (r_flag & ~w_clr);
      r_read_valid <= bus.inputRd;
      if (bus.inputRd) begin
        r_read_out <= bus.inputRdEdge ? w_flag_bit : w_img_bit;
      end
    end
  end

  assign bus.inputImage     = r_image;
  assign bus.inputChanged   = |r_flag;
  assign bus.inputReadOut   = r_read_out;
  assign bus.inputReadValid = r_read_valid;
endmodule
`default_nettype wire

// File: tb/tb_input_reg_sampler.sv
`default_nettype none
// ============================================================================
// tb_input_reg_sampler : directed self-checking bench, 6 inputs, 3-bit address.
// Revision 1.0
// ============================================================================
module tb_input_reg_sampler;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  input_reg_sampler_if #(.INPUT_NUMBER(6), .INPUT_ADDR_LEN(3)) bus ();

  input_reg_sampler #(
    .INPUT_NUMBER(6), .INPUT_ADDR_LEN(3), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [2:0] addr, input logic edge_rd);
    bus.inputRd     = 1'b1;
    bus.inputRdAddr = addr;
    bus.inputRdEdge = edge_rd;
    tick();
    bus.inputRd     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.inputs = 6'h00; bus.inputRd = 1'b0; bus.inputRdAddr = 3'd0; bus.inputRdEdge = 1'b0;
    repeat (3) tick();
    checks++; if (bus.inputImage !== 6'h00) begin errors++; $display("FAIL rst_image got=%h exp=00", bus.inputImage); end
    checks++; if (bus.inputChanged !== 1'b0) begin errors++; $display("FAIL rst_changed got=%b exp=0", bus.inputChanged); end
    checks++; if (bus.inputReadValid !== 1'b0 || bus.inputReadOut !== 1'b0) begin errors++; $display("FAIL rst_read got=%b/%b exp=0/0", bus.inputReadOut, bus.inputReadValid); end
    reset = 1'b0;
    repeat (20) tick();
    checks++; if (bus.inputImage !== 6'h00 || bus.inputChanged !== 1'b0) begin errors++; $display("FAIL idle got=%h/%b exp=00/0", bus.inputImage, bus.inputChanged); end
    do_read(3'd3, 1'b0);
    checks++; if (bus.inputReadOut !== 1'b0 || bus.inputReadValid !== 1'b1) begin errors++; $display("FAIL idle_read got=%b/%b exp=0/1", bus.inputReadOut, bus.inputReadValid); end
    tick();
    checks++; if (bus.inputReadValid !== 1'b0) begin errors++; $display("FAIL valid_pulse got=%b exp=0", bus.inputReadValid); end
  endtask

  task automatic test_debounce_latency();
    bus.inputs[2] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (bus.inputImage[2] !== 1'b0) begin errors++; $display("FAIL early_image edge=%0d got=%b exp=0", n, bus.inputImage[2]); end
    end
    tick();
    checks++; if (bus.inputImage !== 6'b000100 || bus.inputChanged !== 1'b1) begin errors++; $display("FAIL latency got=%h/%b exp=04/1", bus.inputImage, bus.inputChanged); end
    do_read(3'd2, 1'b1);
    checks++; if (bus.inputReadOut !== 1'b1 || bus.inputReadValid !== 1'b1 || bus.inputChanged !== 1'b0) begin errors++; $display("FAIL edge_read got=%b/%b/%b exp=1/1/0", bus.inputReadOut, bus.inputReadValid, bus.inputChanged); end
    do_read(3'd2, 1'b1);
    checks++; if (bus.inputReadOut !== 1'b0) begin errors++; $display("FAIL edge_reread got=%b exp=0", bus.inputReadOut); end
  endtask

  task automatic test_glitch();
    logic seen;
    bus.inputs[5] = 1'b1;
    repeat (3) tick();
    bus.inputs[5] = 1'b0;
    repeat (10) tick();
    checks++; if (bus.inputImage !== 6'b000100 || bus.inputChanged !== 1'b0) begin errors++; $display("FAIL glitch3 got=%h/%b exp=04/0", bus.inputImage, bus.inputChanged); end
    bus.inputs[5] = 1'b1;
    repeat (4) tick();
    bus.inputs[5] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (bus.inputImage[5]) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL pulse4_rise got=%b exp=1", seen); end
    checks++; if (bus.inputImage !== 6'b000100 || bus.inputChanged !== 1'b1) begin errors++; $display("FAIL pulse4_fall got=%h/%b exp=04/1", bus.inputImage, bus.inputChanged); end
    do_read(3'd5, 1'b1);
    checks++; if (bus.inputReadOut !== 1'b1 || bus.inputChanged !== 1'b0) begin errors++; $display("FAIL flag5 got=%b/%b exp=1/0", bus.inputReadOut, bus.inputChanged); end
  endtask

  task automatic test_set_clear_collision();
    bus.inputs[1] = 1'b1;
    repeat (5) tick();
    do_read(3'd1, 1'b1);
    checks++; if (bus.inputReadOut !== 1'b0 || bus.inputReadValid !== 1'b1) begin errors++; $display("FAIL collide_read got=%b/%b exp=0/1", bus.inputReadOut, bus.inputReadValid); end
    checks++; if (bus.inputImage !== 6'b000110 || bus.inputChanged !== 1'b1) begin errors++; $display("FAIL collide_flag got=%h/%b exp=06/1", bus.inputImage, bus.inputChanged); end
  endtask

  task automatic test_back_to_back();
    do_read(3'd1, 1'b0);
    checks++; if (bus.inputReadOut !== 1'b1) begin errors++; $display("FAIL img1 got=%b exp=1", bus.inputReadOut); end
    do_read(3'd7, 1'b1);
    checks++; if (bus.inputReadOut !== 1'b0 || bus.inputReadValid !== 1'b1 || bus.inputChanged !== 1'b1) begin errors++; $display("FAIL oor got=%b/%b/%b exp=0/1/1", bus.inputReadOut, bus.inputReadValid, bus.inputChanged); end
    do_read(3'd1, 1'b1);
    checks++; if (bus.inputReadOut !== 1'b1 || bus.inputChanged !== 1'b0) begin errors++; $display("FAIL flag1 got=%b/%b exp=1/0", bus.inputReadOut, bus.inputChanged); end
    bus.inputRd = 1'b1; bus.inputRdEdge = 1'b0;
    for (int a = 0; a < 3; a++) begin
      bus.inputRdAddr = 3'(a);
      tick();
      checks++; if (bus.inputReadOut !== (a != 0) || bus.inputReadValid !== 1'b1) begin errors++; $display("FAIL b2b addr=%0d got=%b/%b exp=%b/1", a, bus.inputReadOut, bus.inputReadValid, (a != 0)); end
    end
    bus.inputRd = 1'b0;
    tick();
    checks++; if (bus.inputReadValid !== 1'b0 || bus.inputReadOut !== 1'b1) begin errors++; $display("FAIL hold got=%b/%b exp=1/0", bus.inputReadOut, bus.inputReadValid); end
  endtask

  task automatic test_reset_mid_debounce();
    bus.inputs[0] = 1'b1;
    repeat (6) tick();
    checks++; if (bus.inputImage !== 6'b000111 || bus.inputChanged !== 1'b1) begin errors++; $display("FAIL pre_reset got=%h/%b exp=07/1", bus.inputImage, bus.inputChanged); end
    bus.inputs[3] = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.inputImage !== 6'h00 || bus.inputChanged !== 1'b0 || bus.inputReadOut !== 1'b0 || bus.inputReadValid !== 1'b0) begin errors++; $display("FAIL mid_reset got=%h/%b/%b/%b exp=00/0/0/0", bus.inputImage, bus.inputChanged, bus.inputReadOut, bus.inputReadValid); end
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (bus.inputImage !== 6'h00) begin errors++; $display("FAIL redebounce_early edge=%0d got=%h exp=00", n, bus.inputImage); end
    end
    tick();
    checks++; if (bus.inputImage !== 6'b001111 || bus.inputChanged !== 1'b1) begin errors++; $display("FAIL redebounce got=%h/%b exp=0f/1", bus.inputImage, bus.inputChanged); end
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_set_clear_collision();
    test_back_to_back();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
